tmr_voter: RTL and testbench

TMR_VOTER -- requirements
Module: tmr_voter

---
 rtl/tmr_voter_pkg.sv | 26 ++
 rtl/tmr_majority3.sv | 32 +++
 rtl/tmr_voter.sv | 135 +++++++++++++
 tb/tb_tmr_voter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tmr_voter_pkg.sv
// Shared types and constants for the triple-modular-redundancy
// writeback voter.
package tmr_voter_pkg;

  localparam int TUPLE_W = 38;

  localparam logic [2:0] ALL_AGREE   = 3'b111;
  localparam logic [2:0] NO_MAJORITY = 3'b000;

  typedef logic [TUPLE_W-1:0] tuple_t;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    DEGRADED = 2'd1,
    RECOVER  = 2'd2
  } state_t;

  function automatic tuple_t pack_tuple(
    input logic        we,
    input logic [4:0]  rd,
    input logic [31:0] data
  );
    return {we, rd, data};
  endfunction

endpackage

// File: rtl/tmr_majority3.sv
// Combinational 2-of-3 majority over whole writeback tuples,
// with a per-core agreement mask.
module tmr_majority3
  import tmr_voter_pkg::*;
(
  input  tuple_t     t0,
  input  tuple_t     t1,
  input  tuple_t     t2,
  output tuple_t     majority,
  output logic [2:0] agree,
  output logic       has_majority
);

  always_comb begin
    majority     = t0;
    has_majority = 1'b1;
    if (t0 == t1 || t0 == t2) begin
      majority = t0;
    end else if (t1 == t2) begin
      majority = t1;
    end else begin
      has_majority = 1'b0;
    end
    agree = NO_MAJORITY;
    if (has_majority) begin
      agree = {t2 == majority,
               t1 == majority,
               t0 == majority};
    end
  end

endmodule

// File: rtl/tmr_voter.sv
// Registered TMR writeback voter with degraded/recover FSM,
// per-core fault tracking and a saturating error counter.
module tmr_voter
  import tmr_voter_pkg::*;
#(
  parameter int FAULT_THRESH   = 3,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [31:0] wb_data0,
  input  logic [31:0] wb_data1,
  input  logic [31:0] wb_data2,
  input  logic [4:0]  wb_rd0,
  input  logic [4:0]  wb_rd1,
  input  logic [4:0]  wb_rd2,
  input  logic        wb_we0,
  input  logic        wb_we1,
  input  logic        wb_we2,
  output logic        voted_valid,
  output logic [31:0] voted_data,
  output logic [4:0]  voted_rd,
  output logic        voted_we,
  output logic [2:0]  Voter_state,
  output logic [2:0]  core_fault,
  output logic [7:0]  err_count
);

  localparam int MW = $clog2(FAULT_THRESH + 1);
  localparam int RW =
    (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [MW-1:0] MM_MAX   = MW'(FAULT_THRESH);
  localparam logic [RW-1:0] REC_LOAD = RW'(RECOVER_CYCLES - 1);

  tuple_t     t0, t1, t2, maj;
  logic [2:0] agree;
  logic       has_maj;

  assign t0 = pack_tuple(wb_we0, wb_rd0, wb_data0);
  assign t1 = pack_tuple(wb_we1, wb_rd1, wb_data1);
  assign t2 = pack_tuple(wb_we2, wb_rd2, wb_data2);

  tmr_majority3 u_maj (
    .t0           (t0),
    .t1           (t1),
    .t2           (t2),
    .majority     (maj),
    .agree        (agree),
    .has_majority (has_maj)
  );

  state_t state_q, state_d;

  logic               vv_d;
  tuple_t             vt_q, vt_d;
  logic [2:0]         vs_d, fault_d;
  logic [7:0]         err_d;
  logic [RW-1:0]      rec_q, rec_d;
  logic [2:0][MW-1:0] mm_q, mm_d;

  assign {voted_we, voted_rd, voted_data} = vt_q;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) state_q <= NORMAL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL, DEGRADED: begin
        if (valid_in) begin
          if (!has_maj)                state_d = RECOVER;
          else if (agree == ALL_AGREE) state_d = NORMAL;
          else                         state_d = DEGRADED;
        end
      end
      RECOVER: if (rec_q == '0) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // In RECOVER every input tuple is dropped and counters freeze.
  always_comb begin
    vv_d    = 1'b0;
    vt_d    = vt_q;
    vs_d    = Voter_state;
    fault_d = core_fault;
    err_d   = err_count;
    rec_d   = rec_q;
    mm_d    = mm_q;
    if (state_q == RECOVER) begin
      vs_d = ALL_AGREE;
      if (rec_q != '0) rec_d = rec_q - RW'(1);
    end else if (valid_in) begin
      if (has_maj) begin
        vv_d = 1'b1;
        vt_d = maj;
        vs_d = agree;
      end else begin
        vs_d  = NO_MAJORITY;
        rec_d = REC_LOAD;
      end
      if (agree != ALL_AGREE && err_count != 8'hFF)
        err_d = err_count + 8'd1;
      for (int i = 0; i < 3; i++) begin
        if (agree[i])             mm_d[i] = '0;
        else if (mm_q[i] != MM_MAX) mm_d[i] = mm_q[i] + MW'(1);
        if (mm_d[i] == MM_MAX)    fault_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      voted_valid <= 1'b0;
      vt_q        <= '0;
      Voter_state <= ALL_AGREE;
      core_fault  <= '0;
      err_count   <= '0;
      rec_q       <= '0;
      mm_q        <= '0;
    end else begin
      voted_valid <= vv_d;
      vt_q        <= vt_d;
      Voter_state <= vs_d;
      core_fault  <= fault_d;
      err_count   <= err_d;
      rec_q       <= rec_d;
      mm_q        <= mm_d;
    end
  end

endmodule

// File: tb/tb_tmr_voter.sv
// Directed plus randomized bench for tmr_voter against a
// tuple-level reference model.
module tb_tmr_voter;

  localparam int FT = 3;
  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] wb_data0 = '0, wb_data1 = '0, wb_data2 = '0;
  logic [4:0]  wb_rd0 = '0, wb_rd1 = '0, wb_rd2 = '0;
  logic        wb_we0 = 1'b0, wb_we1 = 1'b0, wb_we2 = 1'b0;
  logic        voted_valid;
  logic [31:0] voted_data;
  logic [4:0]  voted_rd;
  logic        voted_we;
  logic [2:0]  Voter_state;
  logic [2:0]  core_fault;
  logic [7:0]  err_count;

  tmr_voter #(.FAULT_THRESH(FT), .RECOVER_CYCLES(RC)) dut (
    .clk(clk), .rst_in(rst_in), .valid_in(valid_in),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .wb_data2(wb_data2),
    .wb_rd0(wb_rd0), .wb_rd1(wb_rd1), .wb_rd2(wb_rd2),
    .wb_we0(wb_we0), .wb_we1(wb_we1), .wb_we2(wb_we2),
    .voted_valid(voted_valid), .voted_data(voted_data),
    .voted_rd(voted_rd), .voted_we(voted_we),
    .Voter_state(Voter_state), .core_fault(core_fault),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 normal, 1 degraded, 2 recovering
  int          m_mode, m_rec, m_err;
  int          m_mm[3];
  logic        m_vv;
  logic [37:0] m_tup;
  logic [2:0]  m_vs, m_fault;
  logic        cur_v;
  logic [37:0] cur[3];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rec = 0; m_err = 0;
    m_vv = 1'b0; m_tup = '0; m_vs = 3'b111; m_fault = '0;
    for (int i = 0; i < 3; i++) m_mm[i] = 0;
  endtask

  task automatic model_step();
    logic [2:0] ag;
    int         w;
    if (m_mode == 2) begin
      m_vv = 1'b0; m_vs = 3'b111; m_rec--;
      if (m_rec == 0) m_mode = 0;
      return;
    end
    if (!cur_v) begin
      m_vv = 1'b0;
      return;
    end
    // a core is in the majority iff it matches some other core
    ag = '0; w = -1;
    for (int i = 0; i < 3; i++) begin
      ag[i] = (cur[i] == cur[(i+1)%3]) || (cur[i] == cur[(i+2)%3]);
      if (ag[i] && w < 0) w = i;
    end
    if (w >= 0) begin
      m_vv = 1'b1; m_tup = cur[w]; m_vs = ag;
      m_mode = (ag == 3'b111) ? 0 : 1;
    end else begin
      m_vv = 1'b0; m_vs = 3'b000; m_mode = 2; m_rec = RC;
    end
    if (ag != 3'b111 && m_err < 255) m_err++;
    for (int i = 0; i < 3; i++) begin
      if (ag[i]) m_mm[i] = 0;
      else if (m_mm[i] < FT) m_mm[i]++;
      if (m_mm[i] == FT) m_fault[i] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".vv"},    64'(voted_valid), 64'(m_vv));
    chk({tag, ".tup"},   64'({voted_we, voted_rd, voted_data}),
                         64'(m_tup));
    chk({tag, ".vs"},    64'(Voter_state), 64'(m_vs));
    chk({tag, ".fault"}, 64'(core_fault), 64'(m_fault));
    chk({tag, ".err"},   64'(err_count), 64'(m_err));
  endtask

  task automatic step(input string tag, input logic v,
                      input logic [37:0] a, b, c);
    cur_v = v; cur[0] = a; cur[1] = b; cur[2] = c;
    valid_in = v;
    {wb_we0, wb_rd0, wb_data0} = a;
    {wb_we1, wb_rd1, wb_data1} = b;
    {wb_we2, wb_rd2, wb_data2} = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic logic [37:0] rnd_tup();
    return {6'($urandom), 32'($urandom)};
  endfunction

  task automatic rand_step(input string tag, input int kind);
    logic [37:0] b, m1, m2;
    int          x, y, d;
    b = rnd_tup();
    x = $urandom_range(0, 37);
    y = (x + 1 + $urandom_range(0, 36)) % 38;
    m1 = 38'd1 << x;
    m2 = 38'd1 << y;
    d = $urandom_range(0, 2);
    case (kind)
      0: step(tag, 1'b1, b, b, b);
      1: step(tag, 1'b1, d == 0 ? b ^ m1 : b,
                         d == 1 ? b ^ m1 : b,
                         d == 2 ? b ^ m1 : b);
      2: step(tag, 1'b1, b, b ^ m1, b ^ m2);
      default: step(tag, 1'b0, b, b ^ m1, rnd_tup());
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [37:0] ta, tb, tc;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.vs_const", 64'(Voter_state), 64'(3'b111));
    rst_in = 1'b1;

    ta = {1'b1, 5'd3, 32'hA5A5A5A5};
    step("all_agree", 1'b1, ta, ta, ta);
    chk("all_agree.data", 64'(voted_data), 64'h A5A5A5A5);
    chk("all_agree.vv", 64'(voted_valid), 64'd1);

    ta = {1'b1, 5'd3, 32'h1234};
    tb = {1'b1, 5'd3, 32'h0};
    step("one_dissent", 1'b1, ta, ta, tb);
    chk("one_dissent.data", 64'(voted_data), 64'h1234);
    chk("one_dissent.vs", 64'(Voter_state), 64'(3'b011));
    chk("one_dissent.err", 64'(err_count), 64'd1);
    step("idle", 1'b0, ta, tb, tb);
    step("back_normal", 1'b1, ta, ta, ta);

    ta = {1'b0, 5'd1, 32'h111};
    tb = {1'b0, 5'd1, 32'h222};
    tc = {1'b0, 5'd1, 32'h333};
    step("no_maj", 1'b1, ta, tb, tc);
    chk("no_maj.vs", 64'(Voter_state), 64'(3'b000));
    for (int i = 0; i < RC; i++) begin
      step("recover", 1'b1, ta, tb, tc);
      chk("recover.vs", 64'(Voter_state), 64'(3'b111));
      chk("recover.vv", 64'(voted_valid), 64'd0);
    end
    step("post_recover", 1'b1, ta, ta, ta);
    chk("post_recover.vv", 64'(voted_valid), 64'd1);

    for (int i = 0; i < FT; i++)
      step("core1_bad", 1'b1, ta, tb, ta);
    chk("core1_fault", 64'(core_fault), 64'(3'b010));
    step("core1_good", 1'b1, ta, ta, ta);
    chk("core1_sticky", 64'(core_fault), 64'(3'b010));

    for (int i = 0; i < 200; i++)
      rand_step("rand", $urandom_range(0, 3));

    step("pre_rst_nomaj", 1'b1, ta, tb, tc);
    step("pre_rst_rec1", 1'b1, ta, ta, ta);
    #2 rst_in = 1'b0;
    #1;
    model_reset();
    check_all("mid_recover_rst");
    @(negedge clk);
    rst_in = 1'b1;
    step("after_rst", 1'b1, ta, ta, ta);
    chk("after_rst.vv", 64'(voted_valid), 64'd1);

    for (int i = 0; i < 300; i++)
      rand_step("sat", 1);
    chk("err_saturate", 64'(err_count), 64'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
